multi_test_runner: RTL and testbench
====================================

Name: multi_test_runner

Overview:
Synthesizable sequencer that drives the req/busy/return handshake of up to NUM_TESTS generated test modules and aggregates their pass/fail results. It runs the tests one at a time or all at once, and applies a settle window and a per-test timeout. Results go to a status register set readable by a top-level bench or an on-chip monitor. It replaces per-test hand-written benches for regression runs.

Parameters:
NUM_TESTS, 4, number of test channels (1..32)
TIMEOUT_CYCLES, 10000, maximum cycles from req assertion to completion before a channel is declared timed out
SETTLE_CYCLES, 5, cycles req is held high; busy is ignored during this window
CNT_W, 32, width of the cycle counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; begins a run when idle
parallel  in  1  sampled on start: 0 = sequential, 1 = all channels at once
test_req  out  NUM_TESTS  per-channel request
test_busy  in  NUM_TESTS  per-channel busy
test_return  in  NUM_TESTS  per-channel result (1 = pass)
running  out  1  run in progress
done  out  1  one-cycle pulse at end of run
all_pass  out  1  every channel returned 1 with no timeout; valid after done
pass_mask  out  NUM_TESTS  per-channel pass
timeout_mask  out  NUM_TESTS  per-channel timeout
run_cycles  out  CNT_W  cycles from start acceptance to done

Behaviour:
- Reset (synchronous, active-high): all outputs go to 0, state goes to IDLE, and the channel index goes to 0. Reset mid-run aborts immediately; test_req is low from the next edge.
- States: IDLE, ISSUE, SETTLE, WAIT, NEXT, FINISH.
- IDLE:
  - start=1 latches the mode and clears pass_mask, timeout_mask and run_cycles, then goes to ISSUE.
  - start while not IDLE is ignored.
- ISSUE (1 cycle):
  - Asserts test_req: bit idx only in sequential mode, all bits in parallel mode.
  - Clears the timeout counter to 0 and goes to SETTLE.
- SETTLE:
  - test_req stays high for exactly SETTLE_CYCLES cycles counted from the first cycle req is high, then drops.
  - Busy is not sampled. Go to WAIT.
  - SETTLE_CYCLES=0: req is high for the ISSUE cycle only.
- WAIT, sequential mode:
  - A channel completes on the first cycle with test_busy[idx]=0.
  - On completion, test_return[idx] is sampled that same cycle into pass_mask[idx].
- WAIT, parallel mode:
  - Each channel completes independently on its first busy-low cycle.
  - Its return is latched that cycle and later changes are ignored.
  - Leave WAIT when all channels have completed or timed out.
- Timeout:
  - The timeout counter increments every cycle from ISSUE.
  - A channel still incomplete when the counter reaches TIMEOUT_CYCLES-1 sets its timeout_mask bit; its pass_mask bit stays 0.
  - If busy goes low on that exact cycle, completion wins and timeout is not set.
- NEXT:
  - Sequential mode: idx+1; go to ISSUE if idx < NUM_TESTS-1, else FINISH.
  - Parallel mode goes straight to FINISH.
- FINISH (1 cycle):
  - done=1 and all_pass = (&pass_mask) & ~(|timeout_mask). all_pass is held until the next start or reset.
  - Go to IDLE.
- running is 1 in every state except IDLE.
- run_cycles:
  - Increments every cycle while running and saturates at all-ones (no wrap).
  - Its value is frozen at FINISH.
- Timing rules:
  - test_req is registered; there is no combinational path from input to output.
  - Inputs are sampled on the rising clk edge.
  - A start arriving in the same cycle as FINISH is ignored; start is accepted only in IDLE.

Test Plan:
1. NUM_TESTS=4, sequential; model each channel as busy high for 20 cycles after req, return=1 -> each test_req pulses 5 cycles in order 0..3, done pulses once, all_pass=1, pass_mask=4'hF, timeout_mask=0.
2. Parallel mode; channel 2 returns 0 and the others return 1 -> all four reqs rise on the same cycle, pass_mask=4'hB, all_pass=0, exactly one done pulse.
3. TIMEOUT_CYCLES=50; channel 1 holds busy high forever -> timeout_mask=4'h2, pass_mask[1]=0, the run continues to channel 2, done asserts, all_pass=0.
4. Busy drops on exactly the timeout cycle -> timeout bit stays 0, pass bit equals test_return.
5. Reset asserted mid-WAIT of channel 2 -> next edge: test_req=0, running=0, masks=0, no done. A following start runs cleanly from channel 0.
6. start pulsed while running -> ignored; run_cycles matches the single-run length and saturates when CNT_W=8 and run length exceeds 255.

Source files
------------

// File: rtl/multi_test_runner.sv
// Sequencer that drives the req/busy/return handshake of generated test channels,
// one at a time or all at once, and collects pass, fail and timeout results.
module multi_test_runner #(
    parameter int NUM_TESTS      = 4,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int SETTLE_CYCLES  = 5,
    parameter int CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 parallel,
    output logic [NUM_TESTS-1:0] test_req,
    input  logic [NUM_TESTS-1:0] test_busy,
    input  logic [NUM_TESTS-1:0] test_return,
    output logic                 running,
    output logic                 done,
    output logic                 all_pass,
    output logic [NUM_TESTS-1:0] pass_mask,
    output logic [NUM_TESTS-1:0] timeout_mask,
    output logic [CNT_W-1:0]     run_cycles
);

    localparam int IDX_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + SETTLE_CYCLES + 2) + 1;

    localparam logic [TO_W-1:0]      TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]      SETTLE_LAST = (SETTLE_CYCLES > 1) ? TO_W'(SETTLE_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(NUM_TESTS - 1);
    localparam logic [NUM_TESTS-1:0] ONE_HOT0    = NUM_TESTS'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    logic [2:0]           state;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_inc;
    logic                 par_mode;
    logic [TO_W-1:0]      tcnt;
    logic                 timed_out;
    logic [NUM_TESTS-1:0] idx_sel;
    logic [NUM_TESTS-1:0] inc_sel;
    logic [NUM_TESTS-1:0] cmpl;
    logic [NUM_TESTS-1:0] cmpl_nxt;
    logic [NUM_TESTS-1:0] pass_nxt;
    logic [NUM_TESTS-1:0] to_nxt;

    assign timed_out = (tcnt >= TO_LAST);
    assign idx_inc   = idx + IDX_W'(1);
    assign idx_sel   = ONE_HOT0 << idx;
    assign inc_sel   = ONE_HOT0 << idx_inc;
    assign running   = (state != S_IDLE);
    assign done      = (state == S_FINISH);

    // Sequential mode pre-marks every other channel complete, so one resolver serves both modes.
    always_comb begin
        cmpl_nxt = cmpl;
        pass_nxt = pass_mask;
        to_nxt   = timeout_mask;
        for (int i = 0; i < NUM_TESTS; i++) begin
            if (!cmpl[i]) begin
                if (!test_busy[i]) begin
                    cmpl_nxt[i] = 1'b1;
                    pass_nxt[i] = test_return[i];
                end else if (timed_out) begin
                    cmpl_nxt[i] = 1'b1;
                    to_nxt[i]   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            idx          <= '0;
            par_mode     <= 1'b0;
            tcnt         <= '0;
            cmpl         <= '0;
            test_req     <= '0;
            all_pass     <= 1'b0;
            pass_mask    <= '0;
            timeout_mask <= '0;
            run_cycles   <= '0;
        end else begin
            if (state != S_IDLE && state != S_FINISH && run_cycles != '1) begin
                run_cycles <= run_cycles + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        par_mode     <= parallel;
                        idx          <= '0;
                        tcnt         <= '0;
                        all_pass     <= 1'b0;
                        pass_mask    <= '0;
                        timeout_mask <= '0;
                        run_cycles   <= '0;
                        test_req     <= parallel ? '1 : ONE_HOT0;
                        state        <= S_ISSUE;
                    end
                end

                // req was raised on entry; the ISSUE cycle is the first counted settle cycle.
                S_ISSUE: begin
                    tcnt <= tcnt + TO_W'(1);
                    cmpl <= par_mode ? '0 : ~idx_sel;
                    if (tcnt >= SETTLE_LAST) begin
                        test_req <= '0;
                    end
                    state <= S_SETTLE;
                end

                S_SETTLE: begin
                    tcnt <= tcnt + TO_W'(1);
                    if (tcnt >= SETTLE_LAST) begin
                        test_req <= '0;
                        state    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    tcnt         <= tcnt + TO_W'(1);
                    cmpl         <= cmpl_nxt;
                    pass_mask    <= pass_nxt;
                    timeout_mask <= to_nxt;
                    if (&cmpl_nxt) begin
                        state <= S_NEXT;
                    end
                end

                S_NEXT: begin
                    if (!par_mode && idx < LAST_IDX) begin
                        idx      <= idx_inc;
                        tcnt     <= '0;
                        test_req <= inc_sel;
                        state    <= S_ISSUE;
                    end else begin
                        all_pass <= (&pass_mask) & ~(|timeout_mask);
                        state    <= S_FINISH;
                    end
                end

                S_FINISH: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_test_runner.sv
// Directed bench for multi_test_runner: per-channel busy/return models and
// hand-computed masks, run lengths and req timing.
module tb_multi_test_runner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        parallel = 1'b0;
    logic [3:0]  test_req;
    logic [3:0]  test_busy = '0;
    logic [3:0]  test_return;
    logic        running, done, all_pass;
    logic [3:0]  pass_mask, timeout_mask;
    logic [31:0] run_cycles;

    logic        start8 = 1'b0;
    logic [1:0]  test_req8;
    logic [1:0]  busy8 = 2'b11;
    logic [1:0]  ret8 = 2'b00;
    logic        running8, done8, all_pass8;
    logic [1:0]  pass8, to8;
    logic [7:0]  run8;

    int          checks = 0;
    int          failures = 0;

    int          dly[4] = '{default: 0};
    int          cnt[4] = '{default: 0};
    logic [3:0]  hang = '0;
    logic [3:0]  ret_cfg = '0;
    logic [3:0]  model_req_d = '0;

    int          done_total = 0;
    int          multi_total = 0;
    int          req_total[4] = '{default: 0};
    int          rises[$];
    logic [3:0]  mon_req_d = '0;

    int          base_done, base_multi, base_rise;
    int          base_req[4];

    assign test_return = ret_cfg;

    always #5 clk = ~clk;

    multi_test_runner #(
        .NUM_TESTS(4), .TIMEOUT_CYCLES(50), .SETTLE_CYCLES(5), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .parallel(parallel),
        .test_req(test_req), .test_busy(test_busy), .test_return(test_return),
        .running(running), .done(done), .all_pass(all_pass),
        .pass_mask(pass_mask), .timeout_mask(timeout_mask), .run_cycles(run_cycles)
    );

    multi_test_runner #(
        .NUM_TESTS(2), .TIMEOUT_CYCLES(200), .SETTLE_CYCLES(5), .CNT_W(8)
    ) dut8 (
        .clk(clk), .reset(reset), .start(start8), .parallel(1'b0),
        .test_req(test_req8), .test_busy(busy8), .test_return(ret8),
        .running(running8), .done(done8), .all_pass(all_pass8),
        .pass_mask(pass8), .timeout_mask(to8), .run_cycles(run8)
    );

    // Each channel stays busy for dly[i] negedges after its req rises, or forever when hung.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (test_req[i] && !model_req_d[i]) cnt[i] = dly[i];
            else if (cnt[i] > 0) cnt[i] = cnt[i] - 1;
            test_busy[i] = hang[i] || (cnt[i] != 0);
        end
        model_req_d = test_req;
    end

    always @(posedge clk) begin
        if (done) done_total++;
        if ($countones(test_req) > 1) multi_total++;
        for (int i = 0; i < 4; i++) begin
            if (test_req[i]) req_total[i]++;
            if (test_req[i] && !mon_req_d[i]) rises.push_back(i);
        end
        mon_req_d = test_req;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic par);
        start    = 1'b1;
        parallel = par;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic setChannels(input int d, input logic [3:0] r, input logic [3:0] h);
        for (int i = 0; i < 4; i++) dly[i] = d;
        ret_cfg = r;
        hang    = h;
    endtask

    task automatic snapshot();
        base_done  = done_total;
        base_multi = multi_total;
        base_rise  = rises.size();
        for (int i = 0; i < 4; i++) base_req[i] = req_total[i];
    endtask

    task automatic waitDone(input bit which, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((which ? done8 : done) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("done_wait", 64'(0), 64'(1));
    endtask

    task automatic checkRun(input string lbl, input logic [3:0] ep, input logic [3:0] eto,
                            input logic ea, input int ecyc);
        checkOutput({lbl, ".pass"}, 64'(pass_mask), 64'(ep));
        checkOutput({lbl, ".timeout"}, 64'(timeout_mask), 64'(eto));
        checkOutput({lbl, ".all_pass"}, 64'(all_pass), 64'(ea));
        checkOutput({lbl, ".run_cycles"}, 64'(run_cycles), 64'(ecyc));
    endtask

    task automatic checkAfter(input string lbl, input logic ea);
        repeat (3) @(negedge clk);
        checkOutput({lbl, ".done_pulses"}, 64'(done_total - base_done), 64'(1));
        checkOutput({lbl, ".running_after"}, 64'(running), 64'(0));
        checkOutput({lbl, ".all_pass_hold"}, 64'(all_pass), 64'(ea));
    endtask

    task automatic checkSequential(input string lbl);
        int n;
        int code;
        n    = rises.size() - base_rise;
        code = 0;
        for (int k = 0; k < n && k < 4; k++) code = code * 4 + rises[base_rise + k];
        checkOutput({lbl, ".rise_count"}, 64'(n), 64'(4));
        checkOutput({lbl, ".rise_order"}, 64'(code), 64'(8'h1B));
        checkOutput({lbl, ".overlap"}, 64'(multi_total - base_multi), 64'(0));
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("%s.req_len%0d", lbl, i), 64'(req_total[i] - base_req[i]), 64'(5));
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit ok;

        repeat (3) @(negedge clk);
        checkOutput("reset.req", 64'(test_req), 64'(0));
        checkOutput("reset.running", 64'(running), 64'(0));
        checkOutput("reset.done", 64'(done), 64'(0));
        checkOutput("reset.run_cycles", 64'(run_cycles), 64'(0));
        checkOutput("reset.running8", 64'(running8), 64'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Sequential, all pass: 22 cycles per channel (ISSUE .. NEXT).
        setChannels(20, 4'hF, 4'h0);
        snapshot();
        applyStimulus(1'b0);
        checkOutput("seq.first_req", 64'(test_req), 64'(4'h1));
        waitDone(1'b0, 2000, ok);
        checkRun("seq", 4'hF, 4'h0, 1'b1, 88);
        checkAfter("seq", 1'b1);
        checkSequential("seq");

        // Parallel, channel 2 fails.
        setChannels(20, 4'b1011, 4'h0);
        snapshot();
        applyStimulus(1'b1);
        checkOutput("par.first_req", 64'(test_req), 64'(4'hF));
        waitDone(1'b0, 2000, ok);
        checkRun("par", 4'hB, 4'h0, 1'b0, 22);
        checkAfter("par", 1'b0);

        // Sequential, channel 1 hangs and times out after 51 cycles.
        setChannels(20, 4'hF, 4'b0010);
        snapshot();
        applyStimulus(1'b0);
        waitDone(1'b0, 2000, ok);
        checkRun("hang", 4'hD, 4'h2, 1'b0, 117);
        checkAfter("hang", 1'b0);
        checkSequential("hang");

        // Parallel timeout boundary: busy low exactly on the last counted cycle vs one later.
        setChannels(10, 4'b1101, 4'h0);
        dly[0] = 49;
        dly[1] = 49;
        dly[2] = 50;
        snapshot();
        applyStimulus(1'b1);
        waitDone(1'b0, 2000, ok);
        checkRun("edge", 4'b1001, 4'b0100, 1'b0, 51);
        checkAfter("edge", 1'b0);

        // Reset in the middle of channel 2's wait.
        setChannels(20, 4'hF, 4'h0);
        applyStimulus(1'b0);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (test_req[2]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("abort.reach_ch2", 64'(ok), 64'(1));
        repeat (10) @(negedge clk);
        snapshot();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort.req", 64'(test_req), 64'(0));
        checkOutput("abort.running", 64'(running), 64'(0));
        checkOutput("abort.pass", 64'(pass_mask), 64'(0));
        checkOutput("abort.timeout", 64'(timeout_mask), 64'(0));
        checkOutput("abort.run_cycles", 64'(run_cycles), 64'(0));
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("abort.no_done", 64'(done_total - base_done), 64'(0));
        snapshot();
        applyStimulus(1'b0);
        checkOutput("rerun.first_req", 64'(test_req), 64'(4'h1));
        waitDone(1'b0, 2000, ok);
        checkRun("rerun", 4'hF, 4'h0, 1'b1, 88);
        checkAfter("rerun", 1'b1);
        checkSequential("rerun");

        // Starts while busy and on the FINISH cycle are both ignored.
        setChannels(20, 4'hF, 4'h0);
        snapshot();
        applyStimulus(1'b0);
        repeat (30) @(negedge clk);
        applyStimulus(1'b1);
        waitDone(1'b0, 2000, ok);
        start    = 1'b1;
        parallel = 1'b0;
        checkRun("ignore", 4'hF, 4'h0, 1'b1, 88);
        @(negedge clk);
        start = 1'b0;
        checkOutput("ignore.start_at_finish", 64'(running), 64'(0));
        checkAfter("ignore", 1'b1);
        checkSequential("ignore");

        // 8-bit counter saturates on a 402-cycle run with both channels timing out.
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        waitDone(1'b1, 1000, ok);
        checkOutput("sat.run_cycles", 64'(run8), 64'(8'hFF));
        checkOutput("sat.timeout", 64'(to8), 64'(2'b11));
        checkOutput("sat.pass", 64'(pass8), 64'(2'b00));
        checkOutput("sat.all_pass", 64'(all_pass8), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
